// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared definitions for the instruction fetch block and its prefetch
//   buffer: default reset PC, PC increment, fetch FSM state encoding and the
//   {pc, inst} buffer entry layout.
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

  // PC loaded when rst_n is asserted, unless the RESET_PC parameter overrides it.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_INC = 32'd4;

  // Width of one prefetch buffer entry: {pc, inst}.
  localparam int unsigned ENTRY_W = 64;

  // Fetch FSM: either fetching sequentially or parked on an inaccessible PC.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Prefetch buffer between the ROM fetch and the decode stage. Entries are
//   {pc, inst} words held in flops; the head entry is driven straight from a
//   storage register, so there is no combinational path from push_data to
//   head_data.
//
//   Ports
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset (clears storage to 0)
//     push       in   write push_data at the tail (ignored when full)
//     push_data  in   entry to write
//     pop        in   drop the head entry (ignored when empty)
//     flush      in   discard all entries; overrides a same-cycle push/pop
//     full       out  DEPTH entries held
//     empty      out  no entries held
//     head_data  out  oldest entry (stale contents while empty)
// ---------------------------------------------------------------------------
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  // Must be a power of two and at least 2, so pointers wrap for free.
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t             mem_q [DEPTH];
  fetch_entry_t             mem_d [DEPTH];
  logic         [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic         [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic         [CNT_W-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  // Guard the caller against overflow/underflow; flush wins over both.
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is reset as well so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Sequential instruction fetcher. Drives the PC onto rom_addr, pushes each
//   accessible {pc, rom_data} into a prefetch buffer and advances the PC by 4.
//   An inaccessible fetch address parks the fetcher in FAULT (PC held, no
//   pushes) while the buffer keeps draining to decode. A redirect flushes the
//   buffer, loads a new PC and restarts fetching from any state.
//
//   Ports
//     clk             in   clock, rising edge
//     rst_n           in   asynchronous active-low reset
//     rom_addr        out  fetch address (the PC register)
//     rom_data        in   instruction word at rom_addr, same cycle
//     rom_accessable  in   rom_addr is mapped and word-aligned
//     redirect_valid  in   load redirect_pc and discard buffered work
//     redirect_pc     in   new fetch PC
//     id_ready        in   decode accepts the head instruction
//     id_valid        out  head instruction is valid
//     id_inst         out  head instruction word
//     id_pc           out  PC of id_inst
//     fetch_fault     out  fetch parked on an inaccessible address
//     fault_pc        out  the address that caused fetch_fault
// ---------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  fetch_entry_t fetch_entry;

  assign rom_addr    = pc_q;
  assign fetch_fault = (state_q == ST_FAULT);
  assign fault_pc    = fault_pc_q;

  assign id_valid = ~fifo_empty;
  assign id_inst  = fifo_head.inst;
  assign id_pc    = fifo_head.pc;

  assign fetch_entry = '{pc: pc_q, inst: rom_data};

  // A redirect discards whatever push or pop would otherwise happen this
  // cycle, so neither the stale fetch nor the decode handshake takes effect.
  assign fifo_push = (state_q == ST_FETCH) & ~fifo_full & rom_accessable & ~redirect_valid;
  assign fifo_pop  = id_valid & id_ready & ~redirect_valid;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fetch_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  // Next-state / PC / fault-address logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          // Fullness is judged on the start-of-cycle occupancy: a full
          // buffer stalls fetch even if decode pops this cycle.
          if (!fifo_full) begin
            if (rom_accessable) begin
              pc_d = next_pc(pc_q);
            end else begin
              fault_pc_d = pc_q;
              state_d    = ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. A behavioural ROM answers rom_addr.
//   Whenever the fetch stream is (re)started (reset or redirect) the driver
//   lists every instruction the decode stage must see, in order, up to the
//   first inaccessible address, which is the expected fault address. A
//   monitor on the falling edge pops that list on every decode handshake and
//   compares pc/inst, checks fault_pc whenever fetch_fault is up, and checks
//   that the head holds steady under backpressure.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_accessable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_fault;

  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  inst_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_accessable (rom_accessable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------ ROM
  // Mapped, word-aligned regions: boot words at 0x0..0x8, a 64-word block
  // at 0x00400000, and the top four words of the address space (so fetch
  // wraps from 0xFFFFFFFC into the boot words).
  function automatic logic rom_ok(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 1'b0;
    return (a <= 32'h8) ||
           (a >= 32'h0040_0000 && a < 32'h0040_0100) ||
           (a >= 32'hFFFF_FFF0);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (!rom_ok(a)) return 32'hDEAD_BEEF;
    case (a)
      32'h0:   return 32'h3c11_4000;
      32'h4:   return 32'h2631_0000;
      32'h8:   return 32'h0220_0008;
      default: return a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  always_comb begin
    rom_accessable = rom_ok(rom_addr);
    rom_data       = rom_word(rom_addr);
  end

  // ------------------------------------------------------------ utilities
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected decode stream after a restart at 'start'.
  task automatic restart_stream(input logic [31:0] start);
    logic [31:0] a;
    a = start;
    exp_q.delete();
    for (int n = 0; n < 256; n++) begin
      if (!rom_ok(a)) break;
      exp_q.push_back({a, rom_word(a)});
      a = a + 32'd4;
    end
    exp_fault = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run until fetch is parked in FAULT with an empty buffer.
  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(fetch_fault && !id_valid) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(fetch_fault && !id_valid), 32'd1);
  endtask

  // -------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (rst_n && !redirect_valid) begin
      if (hold_valid) begin
        check("hold_valid", 32'(id_valid), 32'd1);
        check("hold_pc", id_pc, hold_pc);
        check("hold_inst", id_inst, hold_inst);
      end
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL extra_inst: got pc %h inst %h expected none", id_pc, id_inst);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          $display("consume pc=%h inst=%h", id_pc, id_inst);
          check("id_pc", id_pc, e[63:32]);
          check("id_inst", id_inst, e[31:0]);
        end
      end
      if (fetch_fault) check("fault_pc", fault_pc, exp_fault);
      hold_valid <= id_valid && !id_ready;
      hold_pc    <= id_pc;
      hold_inst  <= id_inst;
    end else begin
      hold_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------- driver
  initial begin
    logic [31:0] rpc;
    int          r;

    rst_n          = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    hold_valid     = 1'b0;
    hold_pc        = '0;
    hold_inst      = '0;
    exp_fault      = '0;

    // Reset values, asserted asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    restart_stream(32'h0);
    #2;
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_rom_addr", rom_addr, 32'h0);

    // Boot with decode always ready: one instruction per cycle.
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("boot0_valid", 32'(id_valid), 32'd1);
    check("boot0_pc", id_pc, 32'h0);
    check("boot0_inst", id_inst, 32'h3c11_4000);
    step();
    check("boot1_pc", id_pc, 32'h4);
    check("boot1_inst", id_inst, 32'h2631_0000);
    step();
    check("boot2_pc", id_pc, 32'h8);
    check("boot2_inst", id_inst, 32'h0220_0008);
    id_ready = 1'b0;
    step();
    check("fault_flag", 32'(fetch_fault), 32'd1);
    check("fault_addr", fault_pc, 32'h0000_000C);
    check("fault_one_left", 32'(id_valid), 32'd1);

    // Redirect out of FAULT with one entry still buffered.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0000;
    restart_stream(32'h0040_0000);
    step();
    check("redir_valid_drop", 32'(id_valid), 32'd0);
    check("redir_fault_clr", 32'(fetch_fault), 32'd0);
    check("redir_rom_addr", rom_addr, 32'h0040_0000);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    step();
    check("redir_first_pc", id_pc, 32'h0040_0000);

    // Fill the buffer, then redirect to a misaligned PC while decode is ready.
    id_ready = 1'b0;
    step();
    step();
    step();
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0002;
    restart_stream(32'h0040_0002);
    step();
    check("sim_empty", 32'(id_valid), 32'd0);
    check("sim_rom_addr", rom_addr, 32'h0040_0002);
    redirect_valid = 1'b0;
    step();
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_fault_pc", fault_pc, 32'h0040_0002);
    check("mis_no_valid", 32'(id_valid), 32'd0);

    // Mid-stream asynchronous reset pulse between clock edges.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0000;
    restart_stream(32'h0040_0000);
    step();
    redirect_valid = 1'b0;
    step();
    step();
    step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    restart_stream(32'h0);
    #1;
    check("arst_id_valid", 32'(id_valid), 32'd0);
    check("arst_id_inst", id_inst, 32'h0);
    check("arst_id_pc", id_pc, 32'h0);
    check("arst_fetch_fault", 32'(fetch_fault), 32'd0);
    check("arst_fault_pc", fault_pc, 32'h0);
    check("arst_rom_addr", rom_addr, 32'h0);

    // Backpressure right after reset: buffer fills, fetch stalls at 0x8.
    id_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("bp_valid", 32'(id_valid), 32'd1);
    check("bp_inst", id_inst, 32'h3c11_4000);
    check("bp_pc", id_pc, 32'h0);
    check("bp_rom_addr", rom_addr, 32'h8);
    id_ready = 1'b1;
    wait_idle(20, "bp_drain");
    check("bp_fault_pc", fault_pc, 32'h0000_000C);
    check("bp_pc_hold", rom_addr, 32'h0000_000C);
    check("bp_stream_done", 32'(exp_q.size()), 32'd0);

    // Randomised traffic: random backpressure, redirects and reset pulses.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      rst_n          = 1'b1;
      redirect_valid = 1'b0;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        rst_n = 1'b0;
        restart_stream(32'h0);
      end else if (r < 40) begin
        case ($urandom_range(0, 5))
          0, 5:    rpc = 32'h0040_0000 + {22'd0, 6'($urandom_range(0, 63)), 2'b00};
          1:       rpc = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
          2:       rpc = 32'h0;
          3:       rpc = 32'h0040_0000 + 32'($urandom_range(1, 3));
          default: rpc = 32'h0000_1000;
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        restart_stream(rpc);
      end
      id_ready = ($urandom_range(0, 3) != 0);
    end

    // Let the last stream run out completely.
    step();
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    wait_idle(400, "final_drain");
    check("final_stream_done", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC loaded on reset.
REQ-002 Parameter: FIFO_DEPTH, 2, prefetch buffer entries; power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: rom_addr  output  32  fetch address to instruction ROM; equals the PC register (combinational).
REQ-006 Port: rom_data  input  32  instruction word from ROM, same cycle as rom_addr.
REQ-007 Port: rom_accessable  input  1  ROM reports that rom_addr is mapped and word-aligned.
REQ-008 Port: redirect_valid  input  1  branch, jump or exception redirect request.
REQ-009 Port: redirect_pc  input  32  new fetch PC, valid with redirect_valid.
REQ-010 Port: id_ready  input  1  decode stage accepts the current instruction.
REQ-011 Port: id_valid  output  1  buffer head holds a valid instruction.
REQ-012 Port: id_inst  output  32  instruction at the buffer head.
REQ-013 Port: id_pc  output  32  PC of id_inst.
REQ-014 Port: fetch_fault  output  1  fetch stopped because the fetch address was inaccessible.
REQ-015 Port: fault_pc  output  32  address that caused fetch_fault.

Function
REQ-016 FSM states: FETCH and FAULT; the FSM enters FETCH on reset.
REQ-017 In FETCH with the buffer not full at the start of the cycle and rom_accessable=1: the block pushes {pc, rom_data} and sets pc to pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-018 In FETCH with the buffer full: no push, and pc holds.
REQ-019 In FETCH with the buffer not full and rom_accessable=0: no push; fault_pc is set to pc; the FSM goes to FAULT.
REQ-020 In FAULT: fetch_fault=1, pc holds, and no pushes occur; the buffer keeps draining to decode.
REQ-021 A pop occurs when id_valid=1 and id_ready=1; id_inst and id_pc are held stable while id_valid=1 and id_ready=0.
REQ-022 A push and a pop in the same cycle are both performed, and the count is unchanged.
REQ-023 Push-to-id_valid latency is 1 cycle; there is no combinational path from rom_data to id_inst.
REQ-024 When redirect_valid=1, in any state: the buffer empties (count 0, id_valid=0 next cycle), pc loads redirect_pc, the FSM goes to FETCH, fetch_fault clears next cycle, and any same-cycle push or pop is discarded.
REQ-025 A misaligned redirect_pc is passed unchanged to rom_addr; the ROM then reports it inaccessible, and the block takes the FAULT path.
REQ-026 Sustained throughput is one instruction per cycle while id_ready=1 and the ROM is accessible.

Reset
REQ-027 Asserting rst_n low asynchronously sets: pc=RESET_PC, state=FETCH, buffer count=0, id_valid=0, id_inst=0, id_pc=0, fetch_fault=0, fault_pc=0.
REQ-028 The first fetch occurs in the first clock cycle after rst_n deasserts; id_valid=1 is reached by the second clock edge.
REQ-029 Reset asserted mid-operation discards all buffered instructions and any pending fault.

Structure
REQ-030 A shared package holds RESET_PC_DEFAULT, the FSM state encoding, and the PC_INC constant (4).
REQ-031 The prefetch buffer is a sub-module, fetch_fifo, with these properties:
- width 64 ({pc, inst});
- push, pop and flush inputs;
- full and empty flags;
- head registered.
REQ-032 inst_fetch contains the PC register, the FSM, and the fault registers only.

Verification
REQ-033 Boot: release reset with the ROM holding boot words 0x3c114000, 0x26310000, 0x02200008 at 0x0, 0x4, 0x8, and id_ready=1 -> id_inst sequence 0x3c114000, 0x26310000, 0x02200008 on consecutive cycles, with id_pc 0x0, 0x4, 0x8.
REQ-034 Backpressure: id_ready=0 for 5 cycles after boot -> the buffer fills to 2; rom_addr holds at 0x8; id_inst holds at 0x3c114000; after release, no instruction is lost or duplicated.
REQ-035 Fault: fetch runs past 0x8 (0xC is unmapped) -> fetch_fault=1 and fault_pc=0x0000000C; buffered instructions still drain; pc holds at 0xC.
REQ-036 Redirect: redirect_valid=1 with redirect_pc=0x00400000 while in FAULT with 1 entry buffered -> next cycle id_valid=0 and fetch_fault=0; the cycle after, id_pc=0x00400000.
REQ-037 Simultaneous events: redirect while the buffer is full and id_ready=1 -> the popped entry is not reported as consumed, and the buffer is empty next cycle; a misaligned redirect_pc=0x00400002 -> FAULT with fault_pc=0x00400002.
REQ-038 Async reset pulse mid-stream, between clock edges -> all outputs reach their reset values immediately; fetch restarts at 0x0.
